pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised, elastic pipeline-stage register; the next generation of our fixed-field stage registers (EX/ME style).
- Carries an opaque DATA_W-bit payload between stages using a valid/ready handshake instead of a global enable.
- A 2-entry skid buffer makes in_ready a pure register output, so a downstream stall does not form a combinational path back through the stage.
- Synchronous flush kills in-flight entries; full throughput is 1 transfer/cycle with 1-cycle latency.

Parameters:
- DATA_W, 32, payload width in bits (≥1); callers pack control, instr, pc and data fields into it.
- CNT_W, 16, stall-counter width; used only with PIPE_STAGE_STATS_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream has payload
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data holds a live entry
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload to next stage; registered
- stall_cnt  out  CNT_W  stall-cycle count; port exists only with PIPE_STAGE_STATS_EN

Behaviour:
- Storage: main register (drives out_data/out_valid) plus a skid register. State is one of PS_EMPTY, PS_ONE (main valid) or PS_FULL (main and skid valid).
- Handshakes: acc = in_valid & in_ready; fire = out_valid & out_ready.
- in_ready = (state != PS_FULL). It is a registered flop and is never derived from out_ready.
- Reset (async): state PS_EMPTY, out_valid=0, out_data=0, skid data=0, in_ready=1, stall_cnt=0.
- Flush has the highest synchronous priority:
  - next state PS_EMPTY; out_data and skid data zeroed; in_ready=1 next cycle.
  - acc in the flush cycle is discarded.
  - fire in the flush cycle still counts as consumed downstream; the stage drops the entry either way.
- PS_EMPTY:
  - acc → PS_ONE, main<=in_data.
  - otherwise hold.
- PS_ONE:
  - fire & acc → PS_ONE, main<=in_data (back-to-back streaming).
  - fire & !acc → PS_EMPTY; main data holds its last value (don't-care while out_valid=0).
  - !fire & acc → PS_FULL, skid<=in_data, in_ready falls next cycle.
  - neither → hold.
- PS_FULL:
  - acc is impossible because in_ready=0.
  - fire → PS_ONE, main<=skid, in_ready=1 next cycle.
  - otherwise hold.
- Stability rule: while out_valid & !out_ready, out_data and out_valid do not change (except on flush).
- Latency: in_data accepted in cycle N appears on out_data in cycle N+1 when the stage was empty or draining.
- Ordering: strict FIFO; the skid entry always leaves after the main entry.
- Never drops or duplicates an entry outside flush.
- in_valid may deassert without a handshake; the stage imposes no upstream stability requirement.
- Reset mid-transfer: all entries are lost, with no partial state.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cnt increments each cycle where out_valid & !out_ready.
  - It saturates at 2^CNT_W-1, with no wrap.
  - It is cleared only by rst_n; flush does not clear it.
- Undefined: the stall_cnt port and its logic are absent; the stage behaves identically otherwise.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] pipe_state_e {PS_EMPTY, PS_ONE, PS_FULL};
  - localparam PIPE_STALL_CNT_W_DEF = 16.
- No sub-module: the skid control is small enough to stay in one module, and the saturating counter is inline under the macro.
- Existing fixed stage registers are replaced by instances that pack their fields into in_data.

Test Plan (DATA_W=32):
- Reset with in_valid=1, in_data=0xDEADBEEF held → after release, out_valid=0, out_data=0, in_ready=1; cycle 1 after release out_valid=1, out_data=0xDEADBEEF.
- Stream 0x1..0x8 with out_ready=1 → out_data 0x1..0x8 on consecutive cycles, one cycle after each input, in_ready stays 1.
- Send 0xA,0xB,0xC with out_ready=0 → state PS_FULL after 0xB; in_ready=0; 0xC held upstream. Then raise out_ready → outputs 0xA,0xB,0xC in order, none lost.
- In PS_FULL (0x11 main, 0x22 skid), assert flush with in_valid=1, in_data=0x33 → next cycle out_valid=0, out_data=0, in_ready=1; 0x33 never appears.
- Random valid/ready toggling, 10k cycles, against a scoreboard queue → exact in-order match; in_ready never depends combinationally on out_ready (checked by assertion).
- With PIPE_STAGE_STATS_EN and CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15 (saturated); flush → still 15; rst_n low → 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers.
package pipe_pkg;

    // Occupancy of a skid stage: nothing, main only, or main plus skid.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_STALL_CNT_W_DEF = 16;

endpackage : pipe_pkg

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// in_ready is a flop output, so a downstream stall never forms a
// combinational path back through the stage.
// Optional: define PIPE_STAGE_STATS_EN to add the saturating stall_cnt port.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = PIPE_STALL_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    pipe_state_e       state_reg, state_next;
    logic [DATA_W-1:0] main_reg, main_next;
    logic [DATA_W-1:0] skid_reg, skid_next;
    logic              in_ready_reg;
    logic              acc;
    logic              fire;

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg != PS_EMPTY);
    assign out_data  = main_reg;
    assign acc       = in_valid & in_ready_reg;
    assign fire      = out_valid & out_ready;

    // Next-state and data-path selection; flush overrides everything.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next = PS_EMPTY;
            main_next  = '0;
            skid_next  = '0;
        end else begin
            case (state_reg)
                PS_EMPTY: begin
                    if (acc) begin
                        state_next = PS_ONE;
                        main_next  = in_data;
                    end
                end
                PS_ONE: begin
                    if (acc && fire) begin
                        main_next = in_data;
                    end else if (acc) begin
                        // Downstream stalled while a new beat arrived: park it.
                        state_next = PS_FULL;
                        skid_next  = in_data;
                    end else if (fire) begin
                        // Main data is left as-is; it is invisible with out_valid low.
                        state_next = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    // No accept is possible here because in_ready is low.
                    if (fire) begin
                        state_next = PS_ONE;
                        main_next  = skid_reg;
                    end
                end
                default: begin
                    state_next = PS_EMPTY;
                end
            endcase
        end
    end

    // State, payload and ready registers; in_ready looks only at the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= PS_EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            main_reg     <= main_next;
            skid_reg     <= skid_next;
            in_ready_reg <= (state_next != PS_FULL);
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    assign stall_cnt = stall_cnt_reg;

    // Saturating count of cycles where a live entry is held back; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end
`else
    // Counter width only matters when the statistics port is built.
    if (CNT_W < 1) begin : g_no_stats
    end
`endif

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid. The reference is a plain queue of
// accepted payloads with capacity two: out_valid means "queue non-empty",
// out_data is the queue head, in_ready means "fewer than two held".
module tb_pipe_stage_skid;

`ifdef PIPE_STAGE_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_q[$];
    bit                zero_exp = 1'b1;
    bit                mon_en   = 1'b0;
    int                n_out    = 0;

    pipe_stage_skid #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the reference queue each cycle and
    // retires the head whenever the DUT presents it and downstream takes it.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
                check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
                if (exp_q.size() > 0)
                    check("out_data", 64'(out_data), 64'(exp_q[0]));
                else if (zero_exp)
                    check("out_data_zero", 64'(out_data), 64'(0));
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    $display("out #%0d data=0x%08h", n_out, exp_q[0]);
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    // Completes a cycle whose inputs were set at the falling edge: records the
    // accept/flush into the reference, then wiggles out_ready to prove in_ready
    // does not follow it combinationally.
    task automatic settle();
        logic rdy_before;
        #2;
        if (flush) begin
            exp_q.delete();
            zero_exp = 1'b1;
        end else if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            zero_exp = 1'b0;
        end
        rdy_before = in_ready;
        #1 out_ready = ~out_ready;
        #1;
        total++;
        assert (in_ready === rdy_before)
        else begin
            bad++;
            $display("FAIL in_ready_comb: got %0b expected %0b at %0t", in_ready, rdy_before, $time);
        end
        out_ready = ~out_ready;
    endtask

    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        settle();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset release with a beat already waiting upstream.
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        settle();
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-to-back streaming.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill both entries while stalled, then drain in order.
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while full, with a beat offered in the same cycle.
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomised valid/ready traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 127) == 0));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("drained", 64'(exp_q.size()), 64'(0));

`ifdef PIPE_STAGE_STATS_EN
        // Saturating stall counter: reset, load one entry, stall for 20 cycles.
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("stall_cnt_rst0", 64'(stall_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        zero_exp = 1'b1;
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        #1 check("stall_cnt_sat", 64'(stall_cnt), 64'(15));
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        #1 check("stall_cnt_flush", 64'(stall_cnt), 64'(15));
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("stall_cnt_rst", 64'(stall_cnt), 64'(0));
        rst_n = 1'b1;
`endif

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_stage_skid
